// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   div_state_e : controller states (IDLE, RUN, DONE)
//   DIV_WIDTH   : default operand width
//   DIV_CNT_W   : iteration counter width for the default operand width
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration plus the Kogge-Stone adder it is built on.
//
// div_step ports:
//   rem_in      : partial remainder before the shift
//   q_msb       : quotient/dividend bit shifted into the remainder
//   divisor_mag : divisor magnitude
//   rem_out     : partial remainder after the trial subtraction
//   q_bit       : new quotient bit (1 when the trial result is non-negative)
//
// div_ks_adder ports:
//   a, b, cin   : addends and carry-in
//   sum, cout   : sum and carry-out

module div_ks_adder #(
    parameter int N     = 33,
    parameter int DELAY = 50
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    localparam int L = $clog2(N);

    // Gate delay only matters to timing models of the adder; the synthesized
    // prefix network is identical for any value.
    localparam int unused_delay_ps = DELAY;

    logic [L:0][N-1:0] g;
    logic [L:0][N-1:0] p;
    logic [N-1:0]      p0;

    assign p0 = a ^ b;

    // Carry-in folded into bit 0's generate so the prefix tree needs no
    // extra column.
    assign g[0][0] = (a[0] & b[0]) | (p0[0] & cin);
    if (N > 1) begin : g_g0_hi
        assign g[0][N-1:1] = a[N-1:1] & b[N-1:1];
    end
    assign p[0] = p0;

    for (genvar lvl = 1; lvl <= L; lvl++) begin : g_level
        localparam int D = 1 << (lvl - 1);
        for (genvar i = 0; i < N; i++) begin : g_bit
            if (i >= D) begin : g_merge
                assign g[lvl][i] = g[lvl-1][i] | (p[lvl-1][i] & g[lvl-1][i-D]);
                assign p[lvl][i] = p[lvl-1][i] & p[lvl-1][i-D];
            end else begin : g_pass
                assign g[lvl][i] = g[lvl-1][i];
                assign p[lvl][i] = p[lvl-1][i];
            end
        end
    end

    // Group propagates that already reach bit 0 are never consumed.
    logic unused_p_bits;
    assign unused_p_bits = ^p;

    if (N > 1) begin : g_sum_hi
        assign sum = p0 ^ {g[L][N-2:0], cin};
    end else begin : g_sum_one
        assign sum = p0 ^ cin;
    end
    assign cout = g[L][N-1];

endmodule

module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int DELAY = 50
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] divisor_mag,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           carry;

    assign shifted = {rem_in, q_msb};

    // shifted - divisor as shifted + ~divisor + 1 over WIDTH+1 bits.
    div_ks_adder #(
        .N     (WIDTH + 1),
        .DELAY (DELAY)
    ) u_adder (
        .a    (shifted),
        .b    (~{1'b0, divisor_mag}),
        .cin  (1'b1),
        .sum  (diff),
        .cout (carry)
    );

    // Carry-out set means no borrow: shifted >= divisor. Either kept value is
    // below the divisor, so the top bit is always zero and can be dropped.
    assign q_bit   = carry;
    assign rem_out = carry ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

    logic unused_diff_msb;
    assign unused_diff_msb = diff[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
//
// Ports:
//   clk, reset  : rising-edge clock, asynchronous active-high reset
//   start       : request, accepted whenever busy is low (IDLE or DONE)
//   is_signed   : two's-complement operands when 1, latched with start
//   dividend    : A, latched with start
//   divisor     : B, latched with start
//   busy        : operation in progress; start ignored
//   done        : one-cycle pulse, results valid in that cycle
//   quotient    : result, held until the next done
//   remainder   : result, held until the next done
//   div_zero    : last completed operation had B == 0
//   dbg_state   : current controller state
//
// Handshake: start is a request sampled at a rising edge when busy is low;
// there is no back-pressure on done, the caller must capture in that cycle.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int DELAY = 50
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    div_state_e       state;
    div_state_e       state_nx;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] rem_acc;
    logic [WIDTH-1:0] q_acc;
    logic [WIDTH-1:0] b_mag;
    logic             neg_q;
    logic             neg_r;

    logic             accept;
    logic             b_zero;
    logic             last_step;
    logic [WIDTH-1:0] a_mag_in;
    logic [WIDTH-1:0] b_mag_in;
    logic [WIDTH-1:0] rem_step;
    logic             q_bit;
    logic [WIDTH-1:0] q_step;

    assign accept    = start && (state != RUN);
    assign b_zero    = (divisor == '0);
    assign last_step = (count == CNT_W'(1));

    // The most negative value maps to 2^(WIDTH-1), which is still exact
    // when read as unsigned.
    assign a_mag_in = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    assign b_mag_in = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

    div_step #(
        .WIDTH (WIDTH),
        .DELAY (DELAY)
    ) u_step (
        .rem_in      (rem_acc),
        .q_msb       (q_acc[WIDTH-1]),
        .divisor_mag (b_mag),
        .rem_out     (rem_step),
        .q_bit       (q_bit)
    );

    assign q_step = {q_acc[WIDTH-2:0], q_bit};

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = b_zero ? DONE : RUN;
                end else begin
                    state_nx = IDLE;
                end
            end
            RUN: begin
                if (last_step) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            rem_acc   <= '0;
            q_acc     <= '0;
            b_mag     <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                neg_q   <= is_signed && (dividend[WIDTH-1] != divisor[WIDTH-1]);
                neg_r   <= is_signed && dividend[WIDTH-1];
                rem_acc <= '0;
                q_acc   <= a_mag_in;
                b_mag   <= b_mag_in;
                count   <= CNT_W'(WIDTH);
                if (b_zero) begin
                    // Results go straight out; the raw dividend is returned.
                    quotient  <= '1;
                    remainder <= dividend;
                    div_zero  <= 1'b1;
                end else begin
                    div_zero  <= 1'b0;
                end
            end else if (state == RUN) begin
                rem_acc <= rem_step;
                q_acc   <= q_step;
                count   <= count - CNT_W'(1);
                if (last_step) begin
                    quotient  <= neg_q ? -q_step   : q_step;
                    remainder <= neg_r ? -rem_step : rem_step;
                end
            end
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed corner cases plus random
// operations compared against a plain-arithmetic reference.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    logic [2*W:0] exp_q[$];

    seq_divider #(.WIDTH(W), .DELAY(50)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Reference: {quotient, remainder, div_zero} from language-level arithmetic.
    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        logic signed [W-1:0] sa, sb, sq, sr;
        if (b == 0) return {{W{1'b1}}, a, 1'b1};
        if (!s) return {a / b, a % b, 1'b0};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {a, {W{1'b0}}, 1'b0};
        sa = a;
        sb = b;
        sq = sa / sb;
        sr = sa % sb;
        return {sq, sr, 1'b0};
    endfunction

    // Called at a negedge; drives start for one edge and waits for done.
    // Returns at the negedge inside the done cycle. disturb scrambles the
    // inputs (including start) while the operation runs.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input bit disturb);
        int n  = 0;
        int nb = 0;
        logic [2*W:0] e;
        exp_q.push_back(ref_div(a, b, s));
        start     = 1'b1;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        while (1) begin
            @(negedge clk);
            n++;
            start = 1'b0;
            if (done || n > 40) break;
            if (busy) nb++;
            if (disturb) begin
                start     = 1'($urandom);
                dividend  = $urandom;
                divisor   = $urandom;
                is_signed = 1'($urandom);
            end
        end
        start = 1'b0;
        e = exp_q.pop_front();
        check({tag, "_done"},    {31'd0, done}, 32'd1);
        check({tag, "_latency"}, n, (b == 0) ? 32'd1 : 32'd33);
        check({tag, "_busycyc"}, nb, (b == 0) ? 32'd0 : 32'd32);
        check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
        check({tag, "_q"},  quotient,  e[2*W:W+1]);
        check({tag, "_r"},  remainder, e[W:1]);
        check({tag, "_dz"}, {31'd0, div_zero}, {31'd0, e[0]});
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rs;

        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        check("rst_dz", {31'd0, div_zero}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases
        run_op("u100_7", 32'd100, 32'd7, 1'b0, 1'b0);
        @(negedge clk);
        check("hold_q", quotient, 32'd14);
        check("hold_done_low", {31'd0, done}, 32'd0);
        run_op("s_m100_7", -32'sd100, 32'd7, 1'b1, 1'b0);
        @(negedge clk);
        run_op("s_100_m7", 32'd100, -32'sd7, 1'b1, 1'b0);
        @(negedge clk);
        run_op("u_div0", 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        run_op("u9_3", 32'd9, 32'd3, 1'b0, 1'b0);
        @(negedge clk);
        run_op("s_div0", 32'h8000_0001, 32'd0, 1'b1, 1'b0);
        @(negedge clk);
        run_op("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0);
        @(negedge clk);
        run_op("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        @(negedge clk);
        run_op("disturb", 32'd100, 32'd7, 1'b0, 1'b1);
        // Back-to-back: new start lands in the done cycle.
        run_op("b2b", 32'd50, 32'd5, 1'b0, 1'b0);
        run_op("b2b_div0", 32'd77, 32'd0, 1'b0, 1'b0);
        run_op("b2b_after0", 32'd77, 32'd7, 1'b1, 1'b0);
        @(negedge clk);

        // Reset in the middle of an operation
        start     = 1'b1;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        is_signed = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_q", quotient, 32'd0);
        check("abort_r", remainder, 32'd0);
        check("abort_dz", {31'd0, div_zero}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", {31'd0, done}, 32'd0);
        end
        reset = 1'b0;
        @(negedge clk);
        run_op("after_abort", 32'd1000, 32'd3, 1'b0, 1'b0);
        @(negedge clk);

        // Random operations
        for (int i = 0; i < 24; i++) begin
            ra = (($urandom & 3) == 0) ? 32'($urandom_range(0, 1000)) : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1, 2, 3: rb = 32'($urandom_range(1, 255));
                4:       rb = -32'($urandom_range(1, 255));
                default: rb = $urandom;
            endcase
            rs = 1'($urandom);
            run_op("rand", ra, rb, rs, 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
